// File: rtl/u232c_rx_fifo.sv
// u232c_rx_fifo -- RS-232 receiver with an integrated receive FIFO.
//
// Samples the serial line at mid-bit after a 2-flop synchronizer. It
// supports a configurable bit period, data width (5..8) and parity
// (0 none, 1 even, 2 odd). Each received character is queued together with
// its frame/parity status. Consumers read the head through a valid/ready
// handshake.
//
// Ports:
//   CLK          in   system clock (single domain)
//   XRST         in   synchronous active-low reset
//   enable       in   receiver enable; 0 aborts a frame and holds IDLE
//   rx           in   asynchronous serial input, idles high
//   data         out  FIFO head character (show-ahead), 0 when empty
//   frame_err    out  FIFO head status: stop bit sampled low
//   parity_err   out  FIFO head status: parity mismatch
//   valid        out  FIFO non-empty
//   ready        in   consumer accepts head; pop on valid && ready
//   count        out  number of FIFO entries
//   overflow     out  sticky: a character was dropped on a full FIFO
//   clr_overflow in   clears overflow (a same-cycle set wins)
module u232c_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 143,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned DEPTH_LOG2   = 4
) (
  input  logic                  CLK,
  input  logic                  XRST,
  input  logic                  enable,
  input  logic                  rx,
  output logic [DATA_BITS-1:0]  data,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  valid,
  input  logic                  ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int unsigned CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned EW    = DATA_BITS + 2;
  localparam int unsigned NW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD_MODE  = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  // ---------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rxs;

  always_ff @(posedge CLK) begin
    if (!XRST) sync_q <= '1;
    else       sync_q <= {sync_q[0], rx};
  end

  assign rxs = sync_q[1];

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   push;
  logic                   push_fe;

  always_ff @(posedge CLK) begin
    if (!XRST) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
    end
  end

  // cyc_q counts edges since the last sampling point (or since T0). A
  // sample is therefore taken on the edge where cyc_q holds period-1.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    push    = 1'b0;
    push_fe = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cyc_d  = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == DATA_LAST) state_d = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          perr_d  = ((^shift_q) ^ rxs) != ODD_MODE;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          push    = 1'b1;
          push_fe = ~rxs;
          state_d = rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cyc_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Disable overrides every state and discards the partial frame.
    if (!enable) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      push    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  logic [EW-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   full;
  logic                   pop;
  logic                   wr_en;
  logic [EW-1:0]          head;

  assign valid = (count_q != '0);
  assign full  = (count_q == NW'(DEPTH));
  assign pop   = valid & ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (clr_overflow)             ovf_d = 1'b0;
    if (push & full & ~pop)       ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!XRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_fe, perr_q, shift_q};
  end

  // Storage is not reset, so the head is masked while empty.
  assign head       = valid ? mem_q[rd_ptr_q] : '0;
  assign data       = head[DATA_BITS-1:0];
  assign parity_err = head[DATA_BITS];
  assign frame_err  = head[DATA_BITS+1];
  assign count      = count_q;
  assign overflow   = ovf_q;

endmodule
